// File: rtl/bram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_pkg                                                             |
// | Shared defaults and controller state encoding for bram_rw_ctrl.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bram_pkg;

   localparam int DEF_NUM_COL    = 4;
   localparam int DEF_COL_WIDTH  = 2;
   localparam int DEF_ADDR_WIDTH = 4;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } ctrlState_t;

endpackage
`default_nettype wire

// File: rtl/bram_rsp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_rsp_fifo                                                        |
// | Two-entry in-order response FIFO; push and pop may coincide when full|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bram_rsp_fifo #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             empty,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wrPtr;
   logic             r_rdPtr;
   logic [1:0]       r_count;
   logic             w_doPop;
   logic             w_doPush;

   assign w_doPop  = pop & (r_count != 2'd0);
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign w_doPush = push & ((r_count != 2'd2) | w_doPop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= 1'b0;
         r_rdPtr <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_doPush) r_wrPtr <= ~r_wrPtr;
         if (w_doPop)  r_rdPtr <= ~r_rdPtr;
         r_count <= r_count + {1'b0, w_doPush} - {1'b0, w_doPop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_doPush) r_mem[r_wrPtr] <= pushData;
   end

   assign popData = r_mem[r_rdPtr];
   assign empty   = (r_count == 2'd0);
   assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/bram_rw_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_rw_ctrl                                                         |
// | Request/response front end for a 1-cycle-latency byte-enable BRAM.  |
// | Define BRAM_RW_CTRL_INIT_EN to zero the memory on leaving reset.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bram_rw_ctrl
   import bram_pkg::*;
#(
   parameter  int NUM_COL    = DEF_NUM_COL,
   parameter  int COL_WIDTH  = DEF_COL_WIDTH,
   parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
   localparam int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [NUM_COL-1:0]    req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_din,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_dout,
   output logic                  bram_ena,
   output logic [NUM_COL-1:0]    bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_din,
   input  logic [DATA_WIDTH-1:0] bram_dout,
   output logic                  init_done
);

   ctrlState_t r_state;
   ctrlState_t w_stateNext;
   logic       r_rdInflight;
   logic       w_isRead;
   logic       w_accept;
   logic       w_rdFull;
   logic       w_sweepWr;
   logic       w_fifoEmpty;
   logic [1:0] w_fifoCount;
   logic [2:0] w_rdLoad;

`ifdef BRAM_RW_CTRL_INIT_EN
   localparam logic [ADDR_WIDTH-1:0] c_lastAddr = '1;

   logic                  r_sweepOn;
   logic [ADDR_WIDTH-1:0] r_initAddr;

   // The first INIT cycle is idle, matching the single INIT cycle of the
   // non-sweeping build; the sweep then covers every address once.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sweepOn  <= 1'b0;
         r_initAddr <= '0;
      end else if (r_state == ST_INIT) begin
         r_sweepOn <= 1'b1;
         if (r_sweepOn) r_initAddr <= r_initAddr + ADDR_WIDTH'(1);
      end
   end

   assign w_sweepWr = (r_state == ST_INIT) & r_sweepOn & ~rst;
`else
   assign w_sweepWr = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_INIT;
      else     r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_INIT: begin
`ifdef BRAM_RW_CTRL_INIT_EN
            if (r_sweepOn && (r_initAddr == c_lastAddr)) w_stateNext = ST_RUN;
`else
            w_stateNext = ST_RUN;
`endif
         end
         ST_RUN:  w_stateNext = ST_RUN;
         default: w_stateNext = ST_INIT;
      endcase
   end

   // Outstanding reads may never exceed the two FIFO slots.
   assign w_rdLoad  = {1'b0, w_fifoCount} + {2'b00, r_rdInflight};
   assign w_rdFull  = (w_rdLoad >= 3'd2);
   assign w_isRead  = (req_we == '0);
   assign req_ready = (r_state == ST_RUN) & ~rst & ~(w_isRead & w_rdFull);
   assign w_accept  = req_valid & req_ready;
   assign init_done = (r_state == ST_RUN);

   always_comb begin
      bram_ena  = w_accept | w_sweepWr;
      bram_we   = '0;
      bram_addr = req_addr;
      bram_din  = req_din;
      if (w_sweepWr) begin
         bram_we   = '1;
`ifdef BRAM_RW_CTRL_INIT_EN
         bram_addr = r_initAddr;
`endif
         bram_din  = '0;
      end else if (w_accept) begin
         bram_we   = req_we;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_rdInflight <= 1'b0;
      else     r_rdInflight <= w_accept & w_isRead;
   end

   bram_rsp_fifo #(
      .WIDTH (DATA_WIDTH)
   ) u_rspFifo (
      .clk      (clk),
      .rst      (rst),
      .push     (r_rdInflight),
      .pushData (bram_dout),
      .pop      (rsp_valid & rsp_ready),
      .popData  (rsp_dout),
      .empty    (w_fifoEmpty),
      .count    (w_fifoCount)
   );

   assign rsp_valid = ~w_fifoEmpty;

endmodule
`default_nettype wire

// File: doc/bram_rw_ctrl.md
BRAM_RW_CTRL -- requirements
Module: bram_rw_ctrl

Interface
REQ-001 SHALL have parameter NUM_COL, default 4, number of byte-enable columns per word.
REQ-002 SHALL have parameter COL_WIDTH, default 2, bits per column.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, word address bits; depth = 2**ADDR_WIDTH.
REQ-004 SHALL have derived parameter DATA_WIDTH = NUM_COL*COL_WIDTH, not overridable.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk  input  1  clock, all logic on rising edge; rst  input  1  synchronous active-high reset.
REQ-006 SHALL have these request ports: req_valid  input  1  request present; req_ready  output  1  request accepted when high with req_valid; req_we  input  NUM_COL  column write mask, 0 = read; req_addr  input  ADDR_WIDTH  word address; req_din  input  DATA_WIDTH  write data.
REQ-007 SHALL have these response ports: rsp_valid  output  1  read data present; rsp_ready  input  1  consumer accepts; rsp_dout  output  DATA_WIDTH  read data.
REQ-008 SHALL have these BRAM port-A ports: bram_ena  output  1; bram_we  output  NUM_COL; bram_addr  output  ADDR_WIDTH; bram_din  output  DATA_WIDTH; bram_dout  input  DATA_WIDTH, registered with 1-cycle read latency.
REQ-009 SHALL have init_done  output  1  memory ready for requests.

Function
REQ-010 SHALL drive bram_ena = req_valid & req_ready, with bram_we/addr/din = req_we/addr/din combinationally in the accept cycle N.
REQ-011 SHALL hold bram_ena=0 and bram_we=0 when no request is accepted.
REQ-012 SHALL capture bram_dout at cycle N+1 for an accepted read, into a 2-entry in-order response FIFO.
REQ-013 SHALL produce no response for writes (req_we != 0).
REQ-014 SHALL deassert req_ready for a read when fifo_count + read_inflight >= 2; writes SHALL remain acceptable under that condition.
REQ-015 SHALL drive rsp_valid = FIFO non-empty and pop on rsp_valid & rsp_ready; rsp_dout SHALL be stable while rsp_valid & !rsp_ready.
REQ-016 SHALL allow push and pop in the same cycle with a full FIFO without loss or stall.
REQ-017 SHALL return reads in acceptance order; a read accepted the cycle after a write to the same address SHALL return the written data.
REQ-018 SHALL implement states INIT -> RUN; RUN SHALL be terminal until rst.
REQ-019 SHALL keep req_ready=0 and init_done=0 in INIT.

Reset
REQ-020 SHALL, on rst, set rsp_valid=0, empty the FIFO, clear read_inflight, set bram_ena=0, and set init_done=0.
REQ-021 SHALL discard an in-flight read hit by rst mid-operation, with no response delivered.
REQ-022 SHALL restart the INIT sweep from address 0 when rst is asserted mid-INIT.

Configuration
REQ-023 SHALL, with BRAM_RW_CTRL_INIT_EN defined, sweep in INIT addresses 0..2**ADDR_WIDTH-1, one per cycle, with bram_ena=1, bram_we=all ones, bram_din=0, then enter RUN and set init_done the cycle after the last address.
REQ-024 SHALL, without BRAM_RW_CTRL_INIT_EN, enter RUN and set init_done the first cycle after rst deasserts, leaving memory contents untouched.

Structure
REQ-025 SHALL take the default NUM_COL/COL_WIDTH/ADDR_WIDTH values and the state encoding from the shared header bram_pkg.
REQ-026 SHALL implement the response FIFO as sub-module bram_rsp_fifo (depth 2, width DATA_WIDTH, count output).

Verification
REQ-027 SHALL cover: write 8'h5A to addr 1 and 8'hF0 to addr 3 (we=4'b1111), then read addr 1 and addr 3 -> rsp_dout 8'h5A, then 8'hF0, in order.
REQ-028 SHALL cover: addr 1 holding 8'h5A, write we=4'b0011 din=8'hFF, then read addr 1 -> 8'h5F.
REQ-029 SHALL cover: rsp_ready=0 and 3 back-to-back reads -> 2 accepted, req_ready=0 on the third; raising rsp_ready -> third accepted, 3 responses in order.
REQ-030 SHALL cover: with BRAM_RW_CTRL_INIT_EN, rst, then measure -> init_done rises exactly 17 cycles after rst deasserts (16 sweep cycles + 1); any read then returns 8'h00.
REQ-031 SHALL cover: rst asserted the cycle after a read is accepted -> rsp_valid stays 0 and no stale data appears after reset.
